// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: length header, big-endian words into instruction memory,
// XOR checksum, then releases the core and re-arms when it halts.
module instr_mem_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  input  logic              cpu_halted,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_START, S_RUN, S_ERR
  } state_t;

  state_t        r_state;
  logic [7:0]    r_len_hi;
  logic [15:0]   r_len;
  logic [23:0]   r_shift;
  logic [1:0]    r_bcnt;
  logic [7:0]    r_xor;
  logic [TW-1:0] r_idle;

  logic        w_acc;
  logic [15:0] w_n;
  logic        w_len_bad;
  logic        w_last_word;
  logic        w_idle_to;

  assign w_acc       = in_valid & in_ready;
  assign w_n         = {r_len_hi, in_data};
  assign w_len_bad   = (w_n == 16'd0) || (32'(w_n) > (32'd1 << ADDR_W));
  assign w_last_word = (32'(words_loaded) + 32'd1) == 32'(r_len);
  assign w_idle_to   = (r_idle == TW'(TIMEOUT - 1));

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LEN_HI;
      r_len_hi     <= '0;
      r_len        <= '0;
      r_shift      <= '0;
      r_bcnt       <= '0;
      r_xor        <= '0;
      r_idle       <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      cpu_start    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      case (r_state)
        S_LEN_HI: begin
          in_ready <= 1'b1;
          if (w_acc) begin
            r_len_hi <= in_data;
            r_idle   <= '0;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO, S_DATA, S_CHK: begin
          if (!w_acc) begin
            if (w_idle_to) begin
              r_state  <= S_ERR;
              in_ready <= 1'b0;
              load_err <= 1'b1;
            end else begin
              r_idle <= r_idle + 1'b1;
            end
          end else begin
            r_idle <= '0;
            if (r_state == S_LEN_LO) begin
              r_len        <= w_n;
              words_loaded <= '0;
              r_xor        <= '0;
              r_bcnt       <= '0;
              if (w_len_bad) begin
                r_state  <= S_ERR;
                in_ready <= 1'b0;
                load_err <= 1'b1;
              end else begin
                r_state <= S_DATA;
              end
            end else if (r_state == S_DATA) begin
              r_xor   <= r_xor ^ in_data;
              r_bcnt  <= r_bcnt + 1'b1;
              r_shift <= {r_shift[15:0], in_data};
              // fourth byte completes the word: write it and count it on this edge
              if (r_bcnt == 2'd3) begin
                mem_we       <= 1'b1;
                mem_addr     <= words_loaded[ADDR_W-1:0];
                mem_wdata    <= {r_shift, in_data};
                words_loaded <= words_loaded + 1'b1;
                if (w_last_word) r_state <= S_CHK;
              end
            end else begin
              in_ready <= 1'b0;
              if (in_data == r_xor) begin
                r_state   <= S_START;
                cpu_start <= 1'b1;
                cpu_hold  <= 1'b0;
              end else begin
                r_state  <= S_ERR;
                load_err <= 1'b1;
              end
            end
          end
        end
        S_START: r_state <= S_RUN;
        S_RUN: begin
          if (cpu_halted) begin
            r_state  <= S_LEN_HI;
            cpu_hold <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_ERR;
          in_ready <= 1'b0;
          cpu_hold <= 1'b1;
          load_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a stream-level model predicts writes and outcome,
// a negedge monitor pops expected writes as mem_we pulses appear.
module tb_instr_mem_loader;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 255;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              cpu_halted = 1'b0;
  logic              in_ready, mem_we, cpu_hold, cpu_start, load_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   words_loaded;

  instr_mem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .cpu_halted(cpu_halted),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
  typedef logic [7:0] bq_t[$];

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   n_tests = 0, n_fail = 0, start_cnt = 0;
  bit   m_start, m_err;
  int   m_words;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk1) begin
    if (rst_n) begin
      if (cpu_start) start_cnt++;
      if (mem_we) begin
        if (exp_q.size() == 0) check("unexpected_mem_we", 64'(mem_addr), 64'hFFFF);
        else begin
          mon_e = exp_q.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(mon_e.a));
          check("mem_wdata", 64'(mem_wdata), 64'(mon_e.d));
        end
      end
    end
  end

  // Stream-level reference: length rules, complete words, XOR over data bytes.
  task automatic model(input bq_t s);
    int n, ndb, nw;
    logic [7:0] x;
    m_start = 0; m_err = 0; m_words = 0;
    if (s.size() < 2) return;
    n = int'(s[0]) * 256 + int'(s[1]);
    if (n == 0 || n > (1 << ADDR_W)) begin m_err = 1; return; end
    ndb = s.size() - 2;
    if (ndb > 4 * n) ndb = 4 * n;
    x = '0;
    for (int i = 0; i < ndb; i++) x ^= s[2 + i];
    nw = ndb / 4;
    for (int k = 0; k < nw; k++) begin
      wr_t e;
      e.a = k[ADDR_W-1:0];
      e.d = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
      exp_q.push_back(e);
    end
    m_words = nw;
    if (s.size() > 2 + 4 * n) begin
      if (s[2 + 4 * n] == x) m_start = 1; else m_err = 1;
    end
  endtask

  task automatic build(input int n, input logic [31:0] w[$], input bit bad, output bq_t s);
    logic [7:0] x = '0;
    s = {};
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    foreach (w[i]) for (int b = 3; b >= 0; b--) begin
      s.push_back(w[i][8*b +: 8]);
      x ^= w[i][8*b +: 8];
    end
    s.push_back(bad ? ~x : x);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk1); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    tick(gap);
    while (!in_ready && t < 2000) begin tick(1); t++; end
    if (!in_ready) begin check("in_ready_wait", 64'(in_ready), 64'd1); return; end
    in_data = b; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic send_all(input bq_t s, input int maxgap, input bit noise);
    foreach (s[i]) begin
      if (noise) cpu_halted = (i == s.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    cpu_halted = 1'b0;
  endtask

  task automatic run_load(input bq_t s, input int maxgap, input bit noise);
    model(s);
    start_cnt = 0;
    send_all(s, maxgap, noise);
    tick(6);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    check("words_loaded", 64'(words_loaded), 64'(m_words));
    check("cpu_start_pulses", 64'(start_cnt), 64'(m_start));
    check("load_err", 64'(load_err), 64'(m_err));
    check("cpu_hold", 64'(cpu_hold), 64'(!m_start));
    check("in_ready_after", 64'(in_ready), 64'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; cpu_halted = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_cpu_start", 64'(cpu_start), 64'd0);
    check("rst_load_err", 64'(load_err), 64'd0);
    check("rst_words_loaded", 64'(words_loaded), 64'd0);
    exp_q.delete();
    @(posedge clk1); @(posedge clk1);
    #3 rst_n = 1'b1;
    #1 check("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk1); #1;
    check("in_ready_first_edge", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    bq_t full, s;
    logic [31:0] w[$];
    logic [31:0] prog_w[$] = '{32'h2801000a, 32'h28020014, 32'h2803001e, 32'h0ce77800,
                               32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                               32'hfc000000};
    full = {8'h00, 8'h09};
    foreach (prog_w[i]) for (int b = 3; b >= 0; b--) full.push_back(prog_w[i][8*b +: 8]);
    full.push_back(8'hEE);

    tick(1);
    do_reset();

    // full program, then halt re-arms the loader
    run_load(full, 0, 0);
    check("full_start_once", 64'(start_cnt), 64'd1);
    cpu_halted = 1'b1; tick(1); cpu_halted = 1'b0;
    check("halt_cpu_hold", 64'(cpu_hold), 64'd1);
    check("halt_in_ready", 64'(in_ready), 64'd1);

    // reload without reset, random gaps, halt noise during the load
    run_load(full, 5, 1);

    // bad checksum
    do_reset();
    s = {8'h00, 8'h01, 8'h28, 8'h01, 8'h00, 8'h0a, 8'h00};
    run_load(s, 0, 0);

    // length bounds
    do_reset();
    s = {8'h00, 8'h00};
    run_load(s, 0, 0);
    do_reset();
    s = {8'h04, 8'h01};
    run_load(s, 0, 0);
    do_reset();
    w = {};
    for (int i = 0; i < 1024; i++) w.push_back($urandom);
    build(1024, w, 0, s);
    run_load(s, 0, 0);

    // random short programs, some with corrupted checksum
    for (int k = 0; k < 6; k++) begin
      int n;
      do_reset();
      n = int'($urandom_range(1, 12));
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      build(n, w, ($urandom_range(0, 2) == 0), s);
      run_load(s, 3, 1);
    end

    // stall after byte 2 of word 1
    do_reset();
    s = full[0:7];
    model(s);
    start_cnt = 0;
    send_all(s, 0, 0);
    tick(TIMEOUT - 3);
    check("timeout_not_early", 64'(load_err), 64'd0);
    tick(10);
    check("timeout_err", 64'(load_err), 64'd1);
    check("timeout_in_ready", 64'(in_ready), 64'd0);
    check("timeout_hold", 64'(cpu_hold), 64'd1);
    check("timeout_words", 64'(words_loaded), 64'(m_words));
    check("timeout_writes", 64'(exp_q.size()), 64'd0);
    check("timeout_no_start", 64'(start_cnt), 64'd0);

    // reset mid-load after byte 2 of word 3, then a clean reload from addr 0
    do_reset();
    s = full[0:15];
    model(s);
    send_all(s, 0, 0);
    tick(2);
    check("midload_writes", 64'(exp_q.size()), 64'd0);
    check("midload_words", 64'(words_loaded), 64'd3);
    do_reset();
    run_load(full, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Upstream stage of the 32-bit pipelined processor. It receives a program as a byte stream, writes it into instruction memory, releases the core, and re-arms when the core halts.

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the instruction-memory word-address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum idle cycles between accepted bytes mid-load.
REQ-003 Port clk1  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port in_data  input  8: stream byte.
REQ-006 Port in_valid  input  1: in_data is valid.
REQ-007 Port in_ready  output  1: loader accepts a byte this cycle.
REQ-008 Port mem_we  output  1: instruction-memory write strobe.
REQ-009 Port mem_addr  output  ADDR_W: instruction-memory word address.
REQ-010 Port mem_wdata  output  32: instruction word.
REQ-011 Port cpu_hold  output  1: keeps the core stalled.
REQ-012 Port cpu_start  output  1: one-cycle pulse; the core clears PC, HALTED and TAKEN_BRANCH on it.
REQ-013 Port cpu_halted  input  1: the core's HALTED flag.
REQ-014 Port load_err  output  1: sticky load-error flag.
REQ-015 Port words_loaded  output  ADDR_W+1: count of words written in the current load.

Function
REQ-016 A byte SHALL be accepted only on an edge where in_valid and in_ready are both 1.
REQ-017 The FSM states SHALL be LEN_HI, LEN_LO, DATA, CHK, START, RUN and ERR.
REQ-018 in_ready SHALL be 1 in LEN_HI, LEN_LO, DATA and CHK, and 0 in START, RUN and ERR.
REQ-019 Length handling:
- The LEN_HI byte followed by the LEN_LO byte SHALL form N = {hi,lo}.
- On accepting the LEN_LO byte, the FSM SHALL go to ERR if N==0 or N>2^ADDR_W, else to DATA.
- Accepting the LEN_LO byte SHALL clear words_loaded.
REQ-020 Data bytes SHALL be assembled big-endian: the first byte of each group of four goes to [31:24].
REQ-021 Memory write timing:
- On the edge accepting the 4th byte of a word, mem_we SHALL register to 1 for exactly one cycle.
- During that cycle mem_addr SHALL equal the word index (0 for the first word) and mem_wdata SHALL equal the assembled word.
- words_loaded SHALL increment on the same edge.
REQ-022 mem_we SHALL be 0 in every other cycle.
REQ-023 mem_addr and mem_wdata SHALL hold their last values while mem_we is 0.
REQ-024 A running XOR SHALL cover all DATA bytes only (not the length bytes).
REQ-025 After word N is accepted, the FSM SHALL go to CHK.
REQ-026 On the CHK byte, the FSM SHALL go to START if the byte equals the running XOR, else to ERR.
REQ-027 START SHALL last one cycle with cpu_start=1 and cpu_hold=0, then go to RUN.
REQ-028 RUN behaviour:
- cpu_hold SHALL be 0 in RUN.
- On the first edge with cpu_halted=1, the FSM SHALL go to LEN_HI, with cpu_hold=1 and in_ready=1 from the next cycle.
- cpu_halted SHALL be ignored outside RUN.
REQ-029 cpu_hold SHALL be 1 in LEN_HI, LEN_LO, DATA, CHK and ERR.
REQ-030 In LEN_LO, DATA and CHK, TIMEOUT consecutive cycles without an accepted byte SHALL force ERR; LEN_HI SHALL have no timeout.
REQ-031 ERR behaviour:
- load_err SHALL be 1, cpu_hold 1 and in_ready 0.
- ERR SHALL be left only by reset.
- cpu_start SHALL never pulse on a failed load.
REQ-032 Words already written before an error or reset SHALL NOT be erased; a partial word SHALL be discarded.

Reset
REQ-033 While rst_n=0, immediately and independent of clk1, the block SHALL drive:
- state=LEN_HI, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
- cpu_hold=1, cpu_start=0, load_err=0, words_loaded=0
- XOR, byte count and timeout counter cleared.
REQ-034 in_ready SHALL rise on the first clk1 edge after rst_n deasserts.
REQ-035 A reset mid-load SHALL abort the load; the next load SHALL start at mem_addr 0.

Verification
REQ-036 Full program: stream 00 09, then words 2801000a 28020014 2803001e 0ce77800 0ce77800 00222000 0ce77800 00832800 fc000000, then checksum EE -> nine mem_we pulses at addr 0..8 with those exact words, words_loaded=9, exactly one cpu_start, cpu_hold=0; then cpu_halted=1 -> cpu_hold=1, in_ready=1.
REQ-037 Bad checksum: 00 01, 28 01 00 0a, checksum 00 (correct 23) -> exactly one mem_we, then load_err=1, no cpu_start, cpu_hold=1.
REQ-038 Length bounds with ADDR_W=10:
- N=0 -> ERR after the second byte, no mem_we.
- N=1025 -> ERR.
- N=1024 -> last write at addr 1023, words_loaded=1024.
REQ-039 Random 0-5 cycle in_valid gaps on the REQ-036 stream -> identical writes; a TIMEOUT-cycle stall after byte 2 of a word -> ERR, no further mem_we.
REQ-040 rst_n low after byte 2 of word 3 -> all outputs at REQ-033 values asynchronously; reload of the REQ-036 stream -> writes restart at addr 0 and succeed.
